// File: rtl/loop_sequencer_pkg.sv
// Shared definitions for the loop sequencer: opcodes, FSM states,
// error codes and instruction field helpers.
package loop_sequencer_pkg;

  localparam int INSTR_W = 18;

  // Processing opcodes 0..14
  localparam logic [4:0] OP_MATMUL      = 5'd0;
  localparam logic [4:0] OP_CONV        = 5'd1;
  localparam logic [4:0] OP_ADD         = 5'd2;
  localparam logic [4:0] OP_SUB         = 5'd3;
  localparam logic [4:0] OP_MUL         = 5'd4;
  localparam logic [4:0] OP_DIV         = 5'd5;
  localparam logic [4:0] OP_MAX         = 5'd6;
  localparam logic [4:0] OP_MIN         = 5'd7;
  localparam logic [4:0] OP_RELU        = 5'd8;
  localparam logic [4:0] OP_SIGMOID     = 5'd9;
  localparam logic [4:0] OP_TANH        = 5'd10;
  localparam logic [4:0] OP_SHIFT       = 5'd11;
  localparam logic [4:0] OP_AND         = 5'd12;
  localparam logic [4:0] OP_OR          = 5'd13;
  localparam logic [4:0] OP_ZERO        = 5'd14;
  // Memory opcodes
  localparam logic [4:0] OP_LOAD        = 5'd15;
  localparam logic [4:0] OP_STORE       = 5'd16;
  // Loop opcodes, executed inside the sequencer
  localparam logic [4:0] OP_START_INDEP = 5'd17;
  localparam logic [4:0] OP_START_LOOP  = 5'd18;
  localparam logic [4:0] OP_JUMP_OR_END = 5'd19;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } seq_state_t;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b10;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b11;

  // Opcode lives in bits [0:4]; bit 0 is the MSB.
  function automatic logic [4:0] opcode_of(input logic [0:INSTR_W-1] instr);
    return instr[0:4];
  endfunction

  // Loop count register index lives in bits [5:7].
  function automatic logic [2:0] loop_idx_of(input logic [0:INSTR_W-1] instr);
    return instr[5:7];
  endfunction

endpackage

// File: rtl/loop_sequencer_stack.sv
// Hardware loop stack: each entry holds the loop body start pc, the
// remaining iteration count and the completed iteration count.
module loop_stack
  import loop_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 10,
  parameter int CNT_W = 16,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic             dec,
  input  logic [PC_W-1:0]  push_pc,
  input  logic [CNT_W-1:0] push_cnt,
  output logic [PC_W-1:0]  top_pc,
  output logic [CNT_W-1:0] top_rem,
  output logic [CNT_W-1:0] top_iter,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0]  pc_mem   [DEPTH];
  logic [CNT_W-1:0] rem_mem  [DEPTH];
  logic [CNT_W-1:0] iter_mem [DEPTH];
  logic [LVL_W-1:0] level_r;
  logic [IDX_W-1:0] top_idx_s;
  logic [IDX_W-1:0] push_idx_s;

  assign top_idx_s  = IDX_W'(level_r - LVL_W'(1));
  assign push_idx_s = IDX_W'(level_r);
  assign full       = (level_r == LVL_W'(DEPTH));
  assign empty      = (level_r == '0);
  assign level      = level_r;
  assign top_pc     = empty ? '0 : pc_mem[top_idx_s];
  assign top_rem    = empty ? '0 : rem_mem[top_idx_s];
  assign top_iter   = empty ? '0 : iter_mem[top_idx_s];

  // Stack storage and depth: clear wins, then push, pop, decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        rem_mem[i]  <= '0;
        iter_mem[i] <= '0;
      end
    end else if (clear) begin
      level_r <= '0;
    end else if (push && !full) begin
      pc_mem[push_idx_s]   <= push_pc;
      rem_mem[push_idx_s]  <= push_cnt;
      iter_mem[push_idx_s] <= '0;
      level_r              <= level_r + LVL_W'(1);
    end else if (pop && !empty) begin
      level_r <= level_r - LVL_W'(1);
    end else if (dec && !empty) begin
      rem_mem[top_idx_s]  <= rem_mem[top_idx_s] - CNT_W'(1);
      iter_mem[top_idx_s] <= iter_mem[top_idx_s] + CNT_W'(1);
    end
  end

endmodule

// File: rtl/loop_sequencer.sv
// Instruction sequencer: fetches words, runs loop opcodes on a local
// stack and hands processing/memory instructions out over valid/ready.
module loop_sequencer
  import loop_sequencer_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int LOOP_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    prog_len,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_idx,
  input  logic [CNT_W-1:0]   cfg_count,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [0:INSTR_W-1] imem_data,
  output logic               mem_valid,
  output logic [0:INSTR_W-1] mem_instr,
  input  logic               mem_ready,
  output logic               proc_valid,
  output logic [0:INSTR_W-1] proc_instr,
  input  logic               proc_ready,
  output logic [2:0]         loop_level,
  output logic [CNT_W-1:0]   loop_iter,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         error_code
);

  seq_state_t         state_r, next_state_s;
  logic [PC_W-1:0]    pc_r, next_pc_s, pc_inc_s, prog_len_r;
  logic [0:INSTR_W-1] ir_r, cur_instr_s;
  logic               fresh_r;
  logic [CNT_W-1:0]   cnt_r [8];
  logic               busy_r, done_r, error_r, imem_en_r;
  logic [1:0]         error_code_r, err_code_s;
  logic [PC_W-1:0]    imem_addr_r;
  logic [4:0]         op_s;
  logic [2:0]         idx_s;
  logic               is_proc_s, is_mem_s, in_issue_s;
  logic               advance_s, err_set_s, err_clr_s, clear_s;
  logic               push_s, pop_s, dec_s;
  logic [CNT_W-1:0]   push_cnt_s, top_rem_s, top_iter_s;
  logic [PC_W-1:0]    top_pc_s;
  logic               stk_full_s, stk_empty_s;
  logic [2:0]         stk_level_s;

  // On the first ISSUE cycle the word is still on imem_data; afterwards it is held in ir_r.
  assign cur_instr_s = fresh_r ? imem_data : ir_r;
  assign op_s        = opcode_of(cur_instr_s);
  assign idx_s       = loop_idx_of(cur_instr_s);
  assign is_proc_s   = (op_s <= OP_ZERO);
  assign is_mem_s    = (op_s == OP_LOAD) || (op_s == OP_STORE);
  assign in_issue_s  = (state_r == S_ISSUE);
  assign pc_inc_s    = pc_r + PC_W'(1);
  assign push_cnt_s  = (cnt_r[idx_s] == '0) ? CNT_W'(1) : cnt_r[idx_s];

  assign proc_valid  = in_issue_s && is_proc_s;
  assign mem_valid   = in_issue_s && is_mem_s;
  assign proc_instr  = proc_valid ? cur_instr_s : '0;
  assign mem_instr   = mem_valid ? cur_instr_s : '0;
  assign imem_en     = imem_en_r;
  assign imem_addr   = imem_addr_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign error       = error_r;
  assign error_code  = error_code_r;
  assign loop_level  = stk_level_s;
  assign loop_iter   = top_iter_s;

  loop_stack #(
    .DEPTH (LOOP_DEPTH),
    .PC_W  (PC_W),
    .CNT_W (CNT_W),
    .LVL_W (3)
  ) u_stack (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_s),
    .push     (push_s),
    .pop      (pop_s),
    .dec      (dec_s),
    .push_pc  (pc_inc_s),
    .push_cnt (push_cnt_s),
    .top_pc   (top_pc_s),
    .top_rem  (top_rem_s),
    .top_iter (top_iter_s),
    .level    (stk_level_s),
    .full     (stk_full_s),
    .empty    (stk_empty_s)
  );

  // Next-state, next-pc and stack/error control decode.
  always_comb begin
    next_state_s = state_r;
    next_pc_s    = pc_r;
    advance_s    = 1'b0;
    err_set_s    = 1'b0;
    err_clr_s    = 1'b0;
    err_code_s   = ERR_NONE;
    clear_s      = 1'b0;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    dec_s        = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          clear_s   = 1'b1;
          err_clr_s = 1'b1;
          next_pc_s = '0;
          if (prog_len == '0) begin
            next_state_s = S_DONE;
          end else begin
            next_state_s = S_FETCH;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_FETCH: next_state_s = S_ISSUE;
      S_ISSUE: begin
        if (is_proc_s) begin
          advance_s = proc_ready;
        end else if (is_mem_s) begin
          advance_s = mem_ready;
        end else if ((op_s == OP_START_INDEP) || (op_s == OP_START_LOOP)) begin
          if (stk_full_s) begin
            err_set_s  = 1'b1;
            err_code_s = ERR_OVERFLOW;
          end else begin
            push_s    = 1'b1;
            advance_s = 1'b1;
          end
        end else if (op_s == OP_JUMP_OR_END) begin
          if (stk_empty_s) begin
            err_set_s  = 1'b1;
            err_code_s = ERR_UNDERFLOW;
          end else if (top_rem_s > CNT_W'(1)) begin
            dec_s        = 1'b1;
            next_pc_s    = top_pc_s;
            next_state_s = S_FETCH;
          end else begin
            pop_s     = 1'b1;
            advance_s = 1'b1;
          end
        end else begin
          err_set_s  = 1'b1;
          err_code_s = ERR_ILLEGAL;
        end
      end
      S_DONE: begin
        clear_s      = 1'b1;
        next_state_s = S_IDLE;
      end
      S_ERR:   next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
    if (err_set_s) begin
      next_state_s = S_ERR;
    end else if (advance_s) begin
      next_pc_s    = pc_inc_s;
      next_state_s = (pc_inc_s == prog_len_r) ? S_DONE : S_FETCH;
    end else begin
      next_pc_s = next_pc_s;
    end
  end

  // Sequencer state, pc, program length and instruction register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      pc_r       <= '0;
      prog_len_r <= '0;
      ir_r       <= '0;
      fresh_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      pc_r    <= next_pc_s;
      fresh_r <= (state_r == S_FETCH);
      if ((state_r == S_IDLE) && start) prog_len_r <= prog_len;
      if (fresh_r) ir_r <= imem_data;
    end
  end

  // Loop count registers, writable only while the sequencer is not running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) cnt_r[i] <= '0;
    end else if (cfg_we && !busy_r) begin
      cnt_r[cfg_idx] <= cfg_count;
    end
  end

  // Registered status and fetch outputs, derived from the upcoming state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      imem_en_r    <= 1'b0;
      imem_addr_r  <= '0;
      error_r      <= 1'b0;
      error_code_r <= ERR_NONE;
    end else begin
      busy_r      <= (next_state_s == S_FETCH) || (next_state_s == S_ISSUE);
      done_r      <= (next_state_s == S_DONE);
      imem_en_r   <= (next_state_s == S_FETCH);
      imem_addr_r <= (next_state_s == S_FETCH) ? next_pc_s : '0;
      if (err_set_s) begin
        error_r      <= 1'b1;
        error_code_r <= err_code_s;
      end else if (err_clr_s) begin
        error_r      <= 1'b0;
        error_code_r <= ERR_NONE;
      end
    end
  end

endmodule
